// File: rtl/sw_outarb_pkg.sv
// Shared switch constants: flit layout, flit type codes and the output arbiter state encoding.
package sw_outarb_pkg;

  localparam int PORT = 3;
  localparam int PKTW = 9;

  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sw_outarb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NIN.
module sw_outarb_rr_pick #(
  parameter int NIN  = 4,
  parameter int SELW = 2
) (
  input  logic [NIN-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NIN-1:0]  pick,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] w_cand;

  always_comb begin
    pick   = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NIN; k++) begin
      w_cand = SELW'((int'(ptr) + k) % NIN);
      if (!any && req[w_cand]) begin
        any          = 1'b1;
        pick[w_cand] = 1'b1;
        idx          = w_cand;
      end
    end
  end

endmodule

// File: rtl/sw_outarb.sv
// Per-output round-robin arbiter that locks the crossbar to one input from header to tail flit.
// Optional lock watchdog enabled by defining SW_OUTARB_TIMEOUT_EN.
module sw_outarb
  import sw_outarb_pkg::*;
#(
  parameter int NIN  = PORT + 1,
  parameter int SELW = $clog2(NIN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIN-1:0]  req,
  input  logic [NIN-1:0]  tail,
  output logic [NIN-1:0]  grant,
  output logic [SELW-1:0] sel,
  output logic            busy
);

  arb_state_t      r_state;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_sel;
  logic [NIN-1:0]  r_grant;
  logic            r_busy;

  logic [NIN-1:0]  w_pick;
  logic [SELW-1:0] w_pick_idx;
  logic            w_any;
  logic            w_release;

  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
    return (v == SELW'(NIN - 1)) ? '0 : v + SELW'(1);
  endfunction

  sw_outarb_rr_pick #(
    .NIN  (NIN),
    .SELW (SELW)
  ) u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

`ifdef SW_OUTARB_TIMEOUT_EN
  logic [5:0] r_wdog;

  // Saturates at 63 so an owner still requesting keeps the lock indefinitely.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_LOCKED) || tail[r_sel]) begin
      r_wdog <= '0;
    end else if (r_wdog != 6'd63) begin
      r_wdog <= r_wdog + 6'd1;
    end
  end

  assign w_release = tail[r_sel] || ((r_wdog == 6'd63) && !req[r_sel]);
`else
  assign w_release = tail[r_sel];
`endif

  // Only the owner's tail releases; a dropped owner request alone keeps the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_sel   <= w_pick_idx;
            r_busy  <= 1'b1;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_release) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= wrap_inc(r_sel);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sw_outarb.sv
// Directed vector bench for sw_outarb: table of per-cycle inputs and expected registered outputs.
module tb_sw_outarb;

  localparam int NIN  = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NIN-1:0]  req = '0;
  logic [NIN-1:0]  tail = '0;
  logic [NIN-1:0]  grant;
  logic [SELW-1:0] sel;
  logic            busy;

  always #5 clk = ~clk;

  sw_outarb #(
    .NIN  (NIN),
    .SELW (SELW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .tail  (tail),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] tl;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] s, input logic b);
    total++;
    if (grant !== g || sel !== s || busy !== b) begin
      bad++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
               nm, grant, sel, busy, g, s, b);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] tl,
                     input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.r = r; v.rq = rq; v.tl = tl; v.g = g; v.s = s; v.b = b;
    vt.push_back(v);
  endtask

  int n_busy;

  initial begin
    // inputs of a row are applied before the edge; expectations are the outputs after it
    // single packet from input 2
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0);
    // wrap and skip: ptr=3, req 0011
    add(0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0001, 4'b0000, 2'd0, 0);
    add(0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b0011, 4'b0010, 4'b0000, 2'd1, 0);
    // contention after reset
    add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0);
    add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1);
    add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1);
    add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1);
    add(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0);
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0);
    // foreign tail and dropped owner request, other input waiting
    add(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b1000, 4'b0100, 4'b0010, 2'd1, 1);
    add(0, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1);
    add(0, 4'b1000, 4'b0010, 4'b0000, 2'd1, 0);
    add(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 0);
    // reset mid-packet, owner 2
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
    add(1, 4'b1100, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1);
    // owner tail with simultaneous requests: release first, then arbitrate from ptr=3
    add(0, 4'b1100, 4'b1100, 4'b0000, 2'd2, 0);
    add(0, 4'b1100, 4'b0000, 4'b1000, 2'd3, 1);
    add(0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 0);
    // tail ignored while idle
    add(0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0);

    foreach (vt[i]) begin
      rst  = vt[i].r;
      req  = vt[i].rq;
      tail = vt[i].tl;
      step();
      chk($sformatf("row%0d", i), vt[i].g, vt[i].s, vt[i].b);
    end

    // owner 0 abandons its request without a tail
    rst  = 1'b0;
    req  = 4'b0001;
    tail = 4'b0000;
    step();
    chk("wd_grant", 4'b0001, 2'd0, 1'b1);
    req    = 4'b0000;
    n_busy = 1;
    for (int c = 0; c < 200 && busy; c++) begin
      step();
      if (busy) n_busy++;
    end
`ifdef SW_OUTARB_TIMEOUT_EN
    total++;
    if (n_busy != 64) begin
      bad++;
      $display("FAIL wd_len: got %0d locked cycles, want 64", n_busy);
    end
    chk("wd_released", 4'b0000, 2'd0, 1'b0);
`else
    total++;
    if (n_busy != 201) begin
      bad++;
      $display("FAIL wd_hold: got %0d locked cycles, want 201", n_busy);
    end
    chk("wd_still_locked", 4'b0001, 2'd0, 1'b1);
    tail = 4'b0001;
    step();
    chk("wd_tail_release", 4'b0000, 2'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
